// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared definitions for the CPU inter-stage pipeline latches.
//   W_DATA_DEFAULT  : default width of PC, IR and operand words
//   NOP_IR_DEFAULT  : default instruction word presented for a bubble
//   latch_state_t   : control state of a skid latch (EMPTY, FULL, SKID)
//   occupancy_of()  : number of live entries held in a given state
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

  localparam int          W_DATA_DEFAULT = 32;
  localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } latch_state_t;

  function automatic logic [1:0] occupancy_of(input latch_state_t st);
    case (st)
      FULL:    occupancy_of = 2'd1;
      SKID:    occupancy_of = 2'd2;
      default: occupancy_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One payload register of a pipeline latch. Updates on the falling edge of
// the stage clock, loads d when load is high, and is forced to CLR_VAL
// immediately while clr is low.
//   clk   in    stage clock (falling-edge active)
//   clr   in    asynchronous active-low clear
//   load  in    capture d at the next falling edge
//   d     in    WIDTH  payload to capture
//   q     out   WIDTH  stored payload
// ---------------------------------------------------------------------------
module pipe_entry #(
  parameter int               WIDTH   = 96,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      q <= CLR_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_latch_skid.sv
// ---------------------------------------------------------------------------
// pipe_latch_skid
// Inter-stage pipeline latch carrying PC, instruction and N_OPER operand
// words with a valid/ready handshake, a one-entry skid buffer, stall
// absorption and flush-to-bubble. All state updates on the falling edge.
//   clk        in   stage clock (falling-edge active)
//   clr        in   asynchronous active-low reset
//   in_valid   in   upstream offers a word
//   in_ready   out  latch can accept (registered, NOT skid occupied)
//   in_pc      in   W_DATA           upstream PC
//   in_ir      in   W_DATA           upstream instruction
//   in_ops     in   N_OPER*W_DATA    operands, k at [k*W_DATA +: W_DATA]
//   flush      in   squash held and incoming words
//   out_valid  out  main entry holds a live word
//   out_ready  in   downstream accepts
//   out_pc     out  W_DATA           main entry PC
//   out_ir     out  W_DATA           main entry IR, NOP_IR when not valid
//   out_ops    out  N_OPER*W_DATA    main entry operands
//   occupancy  out  2                live entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_latch_skid
  import cpu_pipe_pkg::*;
#(
  parameter int                W_DATA = W_DATA_DEFAULT,
  parameter int                N_OPER = 2,
  parameter logic [W_DATA-1:0] NOP_IR = W_DATA'(NOP_IR_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_DATA-1:0]        in_pc,
  input  logic [W_DATA-1:0]        in_ir,
  input  logic [N_OPER*W_DATA-1:0] in_ops,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W_DATA-1:0]        out_pc,
  output logic [W_DATA-1:0]        out_ir,
  output logic [N_OPER*W_DATA-1:0] out_ops,
  output logic [1:0]               occupancy
);

  localparam int OPS_W = N_OPER * W_DATA;
  localparam int PAY_W = 2 * W_DATA + OPS_W;

  // Payload layout is {pc, ir, ops}; the main entry clears to a bubble.
  localparam logic [PAY_W-1:0] M_CLR = {{W_DATA{1'b0}}, NOP_IR, {OPS_W{1'b0}}};
  localparam logic [PAY_W-1:0] S_CLR = '0;

  latch_state_t     state, state_next;
  logic             accept, take;
  logic             m_load, s_load;
  logic [PAY_W-1:0] m_d, m_q, s_q, in_payload;
  logic [W_DATA-1:0] m_pc, m_ir;
  logic [OPS_W-1:0]  m_ops;

  assign in_payload        = {in_pc, in_ir, in_ops};
  assign {m_pc, m_ir, m_ops} = m_q;

  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  assign out_pc    = m_pc;
  assign out_ops   = m_ops;
  assign out_ir    = out_valid ? m_ir : NOP_IR;
  assign occupancy = occupancy_of(state);

  pipe_entry #(.WIDTH(PAY_W), .CLR_VAL(M_CLR)) u_main (
    .clk  (clk),
    .clr  (clr),
    .load (m_load),
    .d    (m_d),
    .q    (m_q)
  );

  pipe_entry #(.WIDTH(PAY_W), .CLR_VAL(S_CLR)) u_skid (
    .clk  (clk),
    .clr  (clr),
    .load (s_load),
    .d    (in_payload),
    .q    (s_q)
  );

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flush wins over everything: both entries drop and the main IR is
  // rewritten to the bubble word while PC/operands keep their last values.
  // A Take on the flush edge needs no action here, the word is already gone.
  always_comb begin
    state_next = state;
    m_load     = 1'b0;
    s_load     = 1'b0;
    m_d        = in_payload;
    if (flush) begin
      state_next = EMPTY;
      m_load     = 1'b1;
      m_d        = {m_pc, NOP_IR, m_ops};
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_load     = 1'b1;
            state_next = FULL;
          end
        end
        FULL: begin
          if (take && accept) begin
            m_load = 1'b1;
          end else if (take) begin
            state_next = EMPTY;
          end else if (accept) begin
            s_load     = 1'b1;
            state_next = SKID;
          end
        end
        SKID: begin
          if (take) begin
            m_load     = 1'b1;
            m_d        = s_q;
            state_next = FULL;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_latch_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_latch_skid
// Directed self-checking bench for pipe_latch_skid. A default instance
// (W_DATA=32, N_OPER=2, NOP_IR=0) carries the main scenarios; two 16-bit
// instances (N_OPER=4 with a non-zero bubble word, and N_OPER=1) share its
// clock, reset and handshake and check operand transport.
// ---------------------------------------------------------------------------
module tb_pipe_latch_skid;

  logic        clk = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic [31:0] in_pc = '0, in_ir = '0;
  logic [63:0] in_ops = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_ir;
  logic [63:0] out_ops;
  logic [1:0]  occupancy;

  logic [15:0] w4_in_pc = '0, w4_in_ir = '0;
  logic [63:0] w4_in_ops = '0;
  logic        w4_in_ready, w4_out_valid;
  logic [15:0] w4_out_pc, w4_out_ir;
  logic [63:0] w4_out_ops;
  logic [1:0]  w4_occ;

  logic [15:0] w1_in_pc = '0, w1_in_ir = '0;
  logic [15:0] w1_in_ops = '0;
  logic        w1_in_ready, w1_out_valid;
  logic [15:0] w1_out_pc, w1_out_ir;
  logic [15:0] w1_out_ops;
  logic [1:0]  w1_occ;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_latch_skid dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .in_ops(in_ops), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_ir(out_ir), .out_ops(out_ops), .occupancy(occupancy)
  );

  pipe_latch_skid #(.W_DATA(16), .N_OPER(4), .NOP_IR(16'hDEAD)) u_w4 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(w4_in_ready),
    .in_pc(w4_in_pc), .in_ir(w4_in_ir), .in_ops(w4_in_ops), .flush(flush),
    .out_valid(w4_out_valid), .out_ready(out_ready), .out_pc(w4_out_pc),
    .out_ir(w4_out_ir), .out_ops(w4_out_ops), .occupancy(w4_occ)
  );

  pipe_latch_skid #(.W_DATA(16), .N_OPER(1)) u_w1 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(w1_in_ready),
    .in_pc(w1_in_pc), .in_ir(w1_in_ir), .in_ops(w1_in_ops), .flush(flush),
    .out_valid(w1_out_valid), .out_ready(out_ready), .out_pc(w1_out_pc),
    .out_ir(w1_out_ir), .out_ops(w1_out_ops), .occupancy(w1_occ)
  );

  // Advance past the next falling edge; inputs are driven and outputs
  // sampled 1 time unit later, far from the active edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return {16'h0013, pc[15:0]};
  endfunction

  function automatic logic [63:0] ops_of(input logic [31:0] pc);
    return {pc + 32'd2000, pc + 32'd1000};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_ir    = ir_of(pc);
    in_ops   = ops_of(pc);
  endtask

  task automatic test_reset();
    clr = 1'b0;
    drive(1'b1, 32'h0000_0055);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_ir !== 32'h0) begin failures++; $display("FAIL reset_out_ir got=%h exp=%h", out_ir, 32'h0); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_pc !== 32'h0 || out_ops !== 64'h0) begin failures++; $display("FAIL reset_data got pc=%h ops=%h exp 0", out_pc, out_ops); end
    checks++; if (w4_out_ir !== 16'hDEAD) begin failures++; $display("FAIL reset_w4_bubble got=%h exp=dead", w4_out_ir); end
    clr = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0100);
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin failures++; $display("FAIL reset_first_push got valid=%0b pc=%h exp 1 100", out_valid, out_pc); end
    checks++; if (out_ir !== ir_of(32'h100) || occupancy !== 2'd1) begin failures++; $display("FAIL reset_first_ir got ir=%h occ=%0d exp %h 1", out_ir, occupancy, ir_of(32'h100)); end
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || out_ir !== 32'h0 || occupancy !== 2'd0) begin failures++; $display("FAIL reset_drain got valid=%0b ir=%h occ=%0d exp 0 0 0", out_valid, out_ir, occupancy); end
  endtask

  task automatic test_streaming();
    logic [31:0] pc;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      drive(1'b1, pc);
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== pc) begin failures++; $display("FAIL stream_pc[%0d] got valid=%0b pc=%h exp 1 %h", i, out_valid, out_pc, pc); end
      checks++; if (out_ir !== ir_of(pc) || out_ops !== ops_of(pc)) begin failures++; $display("FAIL stream_data[%0d] got ir=%h ops=%h exp %h %h", i, out_ir, out_ops, ir_of(pc), ops_of(pc)); end
      checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b exp 1 1", i, occupancy, in_ready); end
    end
    drive(1'b0, 32'h0);
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got occ=%0d valid=%0b exp 0 0", occupancy, out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, 32'h10);
    tick();
    checks++; if (occupancy !== 2'd1 || out_pc !== 32'h10) begin failures++; $display("FAIL stall_first got occ=%0d pc=%h exp 1 10", occupancy, out_pc); end
    drive(1'b1, 32'h14);
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_skid got occ=%0d rdy=%0b exp 2 0", occupancy, in_ready); end
    checks++; if (out_pc !== 32'h10 || out_ir !== ir_of(32'h10)) begin failures++; $display("FAIL stall_head got pc=%h ir=%h exp 10 %h", out_pc, out_ir, ir_of(32'h10)); end
    drive(1'b1, 32'h18);
    tick();
    checks++; if (occupancy !== 2'd2 || out_pc !== 32'h10) begin failures++; $display("FAIL stall_held_off got occ=%0d pc=%h exp 2 10", occupancy, out_pc); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h14 || out_ops !== ops_of(32'h14) || occupancy !== 2'd1) begin failures++; $display("FAIL stall_release1 got pc=%h ops=%h occ=%0d exp 14 %h 1", out_pc, out_ops, occupancy, ops_of(32'h14)); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_back got=%0b exp=1", in_ready); end
    tick();
    checks++; if (out_pc !== 32'h18 || out_ir !== ir_of(32'h18) || occupancy !== 2'd1) begin failures++; $display("FAIL stall_release2 got pc=%h ir=%h occ=%0d exp 18 %h 1", out_pc, out_ir, occupancy, ir_of(32'h18)); end
    drive(1'b0, 32'h0);
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got occ=%0d valid=%0b exp 0 0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h20);
    tick();
    drive(1'b1, 32'h24);
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_setup got occ=%0d exp 2", occupancy); end
    flush = 1'b1;
    drive(1'b1, 32'h28);
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_ir !== 32'h0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush_bubble got valid=%0b ir=%h occ=%0d exp 0 0 0", out_valid, out_ir, occupancy); end
    checks++; if (in_ready !== 1'b1 || out_pc !== 32'h20) begin failures++; $display("FAIL flush_hold got rdy=%0b pc=%h exp 1 20", in_ready, out_pc); end
    checks++; if (w4_out_ir !== 16'hDEAD || w4_occ !== 2'd0) begin failures++; $display("FAIL flush_w4_bubble got ir=%h occ=%0d exp dead 0", w4_out_ir, w4_occ); end
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush_no_ghost got valid=%0b occ=%0d exp 0 0", out_valid, occupancy); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h30);
    tick();
    drive(1'b1, 32'h34);
    tick();
    drive(1'b0, 32'h0);
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL areset_setup got occ=%0d exp 2", occupancy); end
    #3;
    clr = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL areset_immediate got valid=%0b occ=%0d rdy=%0b exp 0 0 1", out_valid, occupancy, in_ready); end
    checks++; if (out_pc !== 32'h0 || out_ir !== 32'h0) begin failures++; $display("FAIL areset_data got pc=%h ir=%h exp 0 0", out_pc, out_ir); end
    #1;
    clr = 1'b1;
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL areset_release got occ=%0d valid=%0b exp 0 0", occupancy, out_valid); end
  endtask

  task automatic test_params();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    w4_in_pc = 16'h0200; w4_in_ir = 16'h0A01; w4_in_ops = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    w1_in_pc = 16'h0300; w1_in_ir = 16'h0B01; w1_in_ops = 16'h7777;
    tick();
    w4_in_pc = 16'h0202; w4_in_ir = 16'h0A02; w4_in_ops = {16'hBEEF, 16'h5555, 16'h6666, 16'h8888};
    w1_in_pc = 16'h0302; w1_in_ir = 16'h0B02; w1_in_ops = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    checks++; if (w4_occ !== 2'd2 || w1_occ !== 2'd2 || w4_in_ready !== 1'b0 || w1_in_ready !== 1'b0) begin failures++; $display("FAIL param_skid got occ4=%0d occ1=%0d rdy4=%0b rdy1=%0b exp 2 2 0 0", w4_occ, w1_occ, w4_in_ready, w1_in_ready); end
    checks++; if (w4_out_ops[63:48] !== 16'h1111 || w1_out_ops !== 16'h7777) begin failures++; $display("FAIL param_head got op3=%h op1w=%h exp 1111 7777", w4_out_ops[63:48], w1_out_ops); end
    out_ready = 1'b1;
    tick();
    checks++; if (w4_out_ops !== {16'hBEEF, 16'h5555, 16'h6666, 16'h8888} || w4_out_pc !== 16'h0202) begin failures++; $display("FAIL param_w4_skid got ops=%h pc=%h exp beef555566668888 0202", w4_out_ops, w4_out_pc); end
    checks++; if (w1_out_ops !== 16'hBEEF || w1_out_pc !== 16'h0302 || w1_out_ir !== 16'h0B02 || w1_out_valid !== 1'b1) begin failures++; $display("FAIL param_w1_skid got ops=%h pc=%h ir=%h valid=%0b exp beef 0302 0b02 1", w1_out_ops, w1_out_pc, w1_out_ir, w1_out_valid); end
    tick();
    checks++; if (w4_out_valid !== 1'b0 || w4_out_ir !== 16'hDEAD || w1_out_ir !== 16'h0) begin failures++; $display("FAIL param_drain got valid4=%0b ir4=%h ir1=%h exp 0 dead 0", w4_out_valid, w4_out_ir, w1_out_ir); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_async_reset();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
